// File: rtl/serial_cmp_pkg.sv
// Shared types and helpers for the serial magnitude comparator.
package serial_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cmp_state_t;

    typedef struct packed {
        logic gt;
        logic eq;
        logic lt;
    } cmp_result_t;

    // Width of the digit counter: it must hold the value WIDTH/DIGIT.
    function automatic int cnt_width(input int width, input int digit);
        return $clog2(width / digit + 1);
    endfunction

endpackage

// File: rtl/digit_comparator.sv
// Combinational unsigned comparator for one DIGIT-bit slice.
module digit_comparator #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    assign gt = (x > y);
    assign eq = (x == y);
    assign lt = (x < y);

endmodule

// File: rtl/serial_mag_comparator.sv
// Multi-cycle MSB-first magnitude comparator with start/done handshake.
// It scans DIGIT bits per clock and exits early at the first differing digit.
// Define SERCMP_SIGNED_EN to compare two's-complement operands; the default
// build compares unsigned operands.
module serial_mag_comparator
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             agtb,
    output logic             aeqb,
    output logic             altb
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = cnt_width(WIDTH, DIGIT);

    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_mag_comparator: WIDTH must be >= 2 and divisible by DIGIT");
    end

    cmp_state_t       state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [CW-1:0]    cnt;
    cmp_result_t      flags;
    logic [WIDTH-1:0] cap_a;
    logic [WIDTH-1:0] cap_b;
    logic             dig_gt;
    logic             dig_eq;
    logic             dig_lt;

    // Operand capture mapping: signed operands become offset binary so the
    // unsigned digit scan yields the signed ordering.
    always_comb begin
`ifdef SERCMP_SIGNED_EN
        cap_a = {~a[WIDTH-1], a[WIDTH-2:0]};
        cap_b = {~b[WIDTH-1], b[WIDTH-2:0]};
`else
        cap_a = a;
        cap_b = b;
`endif
    end

    digit_comparator #(
        .DIGIT(DIGIT)
    ) u_digit (
        .x  (sh_a[WIDTH-1 -: DIGIT]),
        .y  (sh_b[WIDTH-1 -: DIGIT]),
        .gt (dig_gt),
        .eq (dig_eq),
        .lt (dig_lt)
    );

    // Control FSM, operand shift registers, digit counter and result flags.
    // NOTE: every register here is assigned with <= so all of them update
    // from the same pre-edge values; blocking = would leak new values
    // into later statements of the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            sh_a  <= '0;
            sh_b  <= '0;
            cnt   <= '0;
            flags <= '0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sh_a  <= cap_a;
                        sh_b  <= cap_b;
                        cnt   <= CW'(NDIG);
                        flags <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!dig_eq) begin
                        flags.gt <= dig_gt;
                        flags.lt <= dig_lt;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else if (cnt == CW'(1)) begin
                        flags.eq <= 1'b1;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else begin
                        sh_a <= sh_a << DIGIT;
                        sh_b <= sh_b << DIGIT;
                        cnt  <= cnt - CW'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign ready = (state == IDLE);
    assign busy  = (state == RUN);
    assign agtb  = flags.gt;
    assign aeqb  = flags.eq;
    assign altb  = flags.lt;

endmodule
